// File: rtl/branch_predict_unit.sv
// Fetch-stage next-PC predictor: 2-bit saturating direction counters, an
// in-order queue of in-flight predictions, and registered mispredict/BTB
// update reporting with pipeline redirect.
module branch_predict_unit #(
  parameter int unsigned S_INDEX    = 7,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] curr_pc,
  input  logic [31:0] predicted_target,
  output logic        predict_taken,
  output logic [31:0] next_pc_pred,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_is_ctrl,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  output logic        predict_en,
  output logic        predictionFailed,
  output logic [31:0] resolved_pc,
  output logic [31:0] expected_next_pc,
  output logic        redirect,
  output logic        order_err
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam int unsigned ENTRIES = 1 << S_INDEX;

  logic [1:0]    ctr      [ENTRIES];
  logic [31:0]   fifo_pc  [FIFO_DEPTH];
  logic [31:0]   fifo_pred[FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic               empty, pop, push, push_eff, mispredict, head_mismatch;
  logic [31:0]        actual_next;
  logic [S_INDEX-1:0] fetch_idx, res_idx;

  // Combinational prediction and resolution decode
  always_comb begin
    fetch_idx     = curr_pc[2 +: S_INDEX];
    res_idx       = resolve_pc[2 +: S_INDEX];
    predict_taken = ctr[fetch_idx][1];
    next_pc_pred  = predict_taken ? predicted_target : curr_pc + 32'd4;
    empty         = (count == '0);
    fetch_ready   = (count != CW'(FIFO_DEPTH));
    pop           = resolve_valid && !empty;
    // A full queue still takes a fetch when the head retires on the same edge.
    push          = fetch_valid && (fetch_ready || pop);
    actual_next   = (resolve_is_ctrl && resolve_taken) ? resolve_target
                                                       : resolve_pc + 32'd4;
    mispredict    = pop && (actual_next != fifo_pred[head]);
    head_mismatch = pop && (fifo_pc[head] != resolve_pc);
    push_eff      = push && !mispredict;
  end

  assign redirect = predictionFailed;

  // Prediction queue storage (contents are qualified by count, no reset needed)
  always_ff @(posedge clk) begin
    if (push_eff) begin
      fifo_pc[tail]   <= curr_pc;
      fifo_pred[tail] <= next_pc_pred;
    end
  end

  // Queue pointers and occupancy; a mispredict flushes everything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mispredict) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)      head <= head + 1'b1;
      if (push_eff) tail <= tail + 1'b1;
      count <= count + CW'(push_eff) - CW'(pop);
    end
  end

  // Saturating direction counters, trained by resolved control instructions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (pop && resolve_is_ctrl) begin
      if (resolve_taken) begin
        if (ctr[res_idx] != 2'b11) ctr[res_idx] <= ctr[res_idx] + 2'b01;
      end else begin
        if (ctr[res_idx] != 2'b00) ctr[res_idx] <= ctr[res_idx] - 2'b01;
      end
    end
  end

  // Registered mispredict report, BTB update and sticky ordering error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      predict_en       <= 1'b0;
      predictionFailed <= 1'b0;
      resolved_pc      <= '0;
      expected_next_pc <= '0;
      order_err        <= 1'b0;
    end else begin
      predict_en       <= mispredict;
      predictionFailed <= mispredict;
      if (mispredict) begin
        resolved_pc      <= resolve_pc;
        expected_next_pc <= actual_next;
      end
      if ((resolve_valid && empty) || head_mismatch) order_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: the stimulus pushes one expected
// report per resolve; a monitor pops it the cycle after and compares.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_ready;
  logic [31:0] curr_pc, predicted_target;
  logic        predict_taken;
  logic [31:0] next_pc_pred;
  logic        resolve_valid, resolve_is_ctrl, resolve_taken;
  logic [31:0] resolve_pc, resolve_target;
  logic        predict_en, predictionFailed, redirect, order_err;
  logic [31:0] resolved_pc, expected_next_pc;

  typedef struct {
    bit          fail;
    logic [31:0] pc;
    logic [31:0] nxt;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  logic rv_d;

  branch_predict_unit #(.S_INDEX(7), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .curr_pc(curr_pc), .predicted_target(predicted_target),
    .predict_taken(predict_taken), .next_pc_pred(next_pc_pred),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_is_ctrl(resolve_is_ctrl), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .predict_en(predict_en), .predictionFailed(predictionFailed),
    .resolved_pc(resolved_pc), .expected_next_pc(expected_next_pc),
    .redirect(redirect), .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic is_ctrl, input logic taken,
                         input logic [31:0] tgt, input bit fail, input logic [31:0] nxt);
    exp_t e;
    resolve_valid   = 1'b1;
    resolve_pc      = pc;
    resolve_is_ctrl = is_ctrl;
    resolve_taken   = taken;
    resolve_target  = tgt;
    e.fail = fail;
    e.pc   = pc;
    e.nxt  = nxt;
    expq.push_back(e);
  endtask

  // Remember which edges carried a resolve so the monitor knows when a report is due
  always @(posedge clk or negedge rst) begin
    if (!rst) rv_d <= 1'b0;
    else      rv_d <= resolve_valid;
  end

  // Monitor: compare the registered report half a cycle after each resolve edge
  always @(negedge clk) begin
    if (rst) begin
      if (rv_d) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got report with no expectation queued");
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("sb_predictionFailed", {31'd0, predictionFailed}, {31'd0, e.fail});
          chk("sb_predict_en", {31'd0, predict_en}, {31'd0, e.fail});
          chk("sb_redirect", {31'd0, redirect}, {31'd0, e.fail});
          if (e.fail) begin
            chk("sb_resolved_pc", resolved_pc, e.pc);
            chk("sb_expected_next_pc", expected_next_pc, e.nxt);
          end
        end
      end else if (predictionFailed || predict_en || redirect) begin
        checks++;
        errors++;
        $display("FAIL sb_spurious: got pf=%0b en=%0b rd=%0b expected 0", predictionFailed, predict_en, redirect);
      end
    end
  end

  initial begin
    rst = 1'b0; fetch_valid = 1'b0; curr_pc = '0; predicted_target = '0;
    resolve_valid = 1'b0; resolve_pc = '0; resolve_is_ctrl = 1'b0;
    resolve_taken = 1'b0; resolve_target = '0;
    cyc; cyc;
    rst = 1'b1;
    cyc;
    // Reset state
    chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
    chk("rst_predict_en", {31'd0, predict_en}, 32'd0);
    chk("rst_predictionFailed", {31'd0, predictionFailed}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_order_err", {31'd0, order_err}, 32'd0);
    chk("rst_resolved_pc", resolved_pc, 32'd0);
    chk("rst_expected_next_pc", expected_next_pc, 32'd0);

    // Weakly not-taken after reset
    curr_pc = 32'h100; predicted_target = 32'h200; #1;
    chk("t1_predict_taken", {31'd0, predict_taken}, 32'd0);
    chk("t1_next_pc_pred", next_pc_pred, 32'h104);
    fetch_valid = 1'b1;
    cyc;
    // Taken to 0x200 mispredicts the queued 0x104; counter 01 -> 10
    fetch_valid = 1'b0;
    resolve(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
    cyc;
    // Redirect cycle: fetch accepted, counter now predicts taken
    resolve_valid = 1'b0;
    fetch_valid = 1'b1; curr_pc = 32'h100; predicted_target = 32'h200; #1;
    chk("t2_next_after_10", next_pc_pred, 32'h200);
    cyc;
    fetch_valid = 1'b0;
    resolve(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    cyc;
    resolve_valid = 1'b0; #1;
    chk("t2_predict_taken_11", {31'd0, predict_taken}, 32'd1);
    chk("t2_next_after_11", next_pc_pred, 32'h200);

    // Entry predicted 0x104, resolved taken to 0x300; same-cycle push discarded
    predicted_target = 32'h104; fetch_valid = 1'b1; #1;
    chk("t3_next_pc_pred", next_pc_pred, 32'h104);
    cyc;
    fetch_valid = 1'b1; curr_pc = 32'h700; predicted_target = 32'h0;
    resolve(32'h100, 1'b1, 1'b1, 32'h300, 1'b1, 32'h300);
    cyc;
    resolve_valid = 1'b0; fetch_valid = 1'b0;
    cyc;
    chk("t3_pf_one_cycle", {31'd0, predictionFailed}, 32'd0);
    chk("t3_resolved_pc_hold", resolved_pc, 32'h100);
    chk("t3_expected_hold", expected_next_pc, 32'h300);

    // Fill to FIFO_DEPTH (also proves the flush left the queue empty)
    for (int i = 0; i < 4; i++) begin
      curr_pc = 32'h400 + 32'(4 * i); predicted_target = 32'h0; fetch_valid = 1'b1; #1;
      chk("t4_ready_filling", {31'd0, fetch_ready}, 32'd1);
      cyc;
    end
    fetch_valid = 1'b0; #1;
    chk("t4_ready_full", {31'd0, fetch_ready}, 32'd0);
    fetch_valid = 1'b1; curr_pc = 32'h410;
    resolve(32'h400, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc;
    fetch_valid = 1'b0; resolve_valid = 1'b0; #1;
    chk("t4_full_after_push_pop", {31'd0, fetch_ready}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      resolve(32'h400 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc;
      resolve_valid = 1'b0; #1;
      chk("t4_ready_draining", {31'd0, fetch_ready}, 32'd1);
    end
    chk("t4_order_ok", {31'd0, order_err}, 32'd0);

    // Non-control resolve, then resolve against an empty queue
    curr_pc = 32'h180; predicted_target = 32'h500; fetch_valid = 1'b1; #1;
    chk("t5_next_pc_pred", next_pc_pred, 32'h184);
    cyc;
    fetch_valid = 1'b0;
    resolve(32'h180, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc;
    resolve_valid = 1'b0; #1;
    chk("t5_counter_unchanged", next_pc_pred, 32'h184);
    chk("t5_order_ok", {31'd0, order_err}, 32'd0);
    resolve(32'h180, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc;
    resolve_valid = 1'b0; #1;
    chk("t5_order_err_empty", {31'd0, order_err}, 32'd1);
    cyc;
    chk("t5_order_err_sticky", {31'd0, order_err}, 32'd1);

    // Asynchronous reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) begin
      curr_pc = 32'h600 + 32'(4 * i); predicted_target = 32'h0; fetch_valid = 1'b1;
      cyc;
    end
    fetch_valid = 1'b0; curr_pc = 32'h100; predicted_target = 32'h200; #1;
    chk("t6_ready_three", {31'd0, fetch_ready}, 32'd1);
    chk("t6_next_before_rst", next_pc_pred, 32'h200);
    rst = 1'b0; #1;
    chk("t6_order_err", {31'd0, order_err}, 32'd0);
    chk("t6_predict_en", {31'd0, predict_en}, 32'd0);
    chk("t6_resolved_pc", resolved_pc, 32'd0);
    chk("t6_expected_next_pc", expected_next_pc, 32'd0);
    chk("t6_counter_reset", next_pc_pred, 32'h104);
    chk("t6_fetch_ready", {31'd0, fetch_ready}, 32'd1);
    cyc;
    rst = 1'b1;
    resolve(32'h600, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc;
    resolve_valid = 1'b0; #1;
    chk("t6_fifo_emptied", {31'd0, order_err}, 32'd1);
    cyc; cyc;
    chk("sb_drained", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
